perf_counter_readout: RTL and testbench



---
 rtl/perf_counter_readout.sv | 138 +++++++++++++
 tb/tb_perf_counter_readout.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_readout.sv
// Performance-counter snapshot reader.
// A request captures every input port's SA local-valid and SA global-inport-read
// counter in a single cycle. The captured values are then streamed out as a
// framed sequence of 32-bit words over a valid/ready interface.
//
// Frame layout (N = INPUT_PORT_NUM):
//   word 0         : header {8'hA5, node_x, node_y, N[3:0], seq}
//   word 1+4i..4+4i: port i local lo, local hi, global lo, global hi
//   word 4N        : last word, rd_last_o asserted
//
// The output word is selected from frozen snapshot registers by the registered
// word index. rd_rdy_i only advances the index and has no combinational path
// to rd_data_o.
//
//   state | meaning
//   IDLE  | no frame pending; a request is captured at the next edge
//   SEND  | streaming snapshot words; requests are ignored
module perf_counter_readout #(
   parameter int INPUT_PORT_NUM = 5,
   parameter int CNT_W          = 64
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [INPUT_PORT_NUM*64-1:0] local_cnt_i,
   input  logic [INPUT_PORT_NUM*64-1:0] global_cnt_i,
   input  logic [1:0]                  node_id_x_i,
   input  logic [1:0]                  node_id_y_i,
   input  logic                        snap_req_i,
   output logic                        snap_busy_o,
   output logic                        snap_done_o,
   output logic                        rd_vld_o,
   input  logic                        rd_rdy_i,
   output logic [31:0]                 rd_data_o,
   output logic                        rd_last_o
);

   localparam int LAST  = 4 * INPUT_PORT_NUM;
   localparam int IDX_W = $clog2(LAST + 1);
   localparam int HALF  = CNT_W / 2;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                          state;
   state_t                          state_nxt;
   logic [IDX_W-1:0]                word_idx;
   logic [15:0]                     seq;
   logic [INPUT_PORT_NUM*CNT_W-1:0] snap_local;
   logic [INPUT_PORT_NUM*CNT_W-1:0] snap_global;
   logic [1:0]                      snap_x;
   logic [1:0]                      snap_y;
   logic [15:0]                     snap_seq;
   logic [31:0]                     word_sel;
   logic                            at_last;
   logic                            take;
   logic                            accept;

   assign at_last = (word_idx == IDX_W'(LAST));
   assign take    = (state == SEND) && rd_rdy_i;
   assign accept  = (state == IDLE) && snap_req_i;

   // State register; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: leave IDLE on a request, return after the last word is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (snap_req_i) state_nxt = SEND;
         SEND: if (rd_rdy_i && at_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the state and registered word index only.
   always_comb begin
      rd_vld_o    = (state == SEND);
      snap_busy_o = (state == SEND);
      rd_last_o   = (state == SEND) && at_last;
      rd_data_o   = (state == SEND) ? word_sel : 32'h0;
   end

   // Word select from the frozen snapshot; header is the default for index 0.
   always_comb begin
      word_sel = {8'hA5, snap_x, snap_y, 4'(INPUT_PORT_NUM), snap_seq};
      for (int p = 0; p < INPUT_PORT_NUM; p++) begin
         if (word_idx == IDX_W'(4*p + 1)) word_sel = snap_local[p*CNT_W +: HALF];
         if (word_idx == IDX_W'(4*p + 2)) word_sel = snap_local[p*CNT_W + HALF +: HALF];
         if (word_idx == IDX_W'(4*p + 3)) word_sel = snap_global[p*CNT_W +: HALF];
         if (word_idx == IDX_W'(4*p + 4)) word_sel = snap_global[p*CNT_W + HALF +: HALF];
      end
   end

   // Snapshot capture and sequence number; frozen for the whole frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         snap_local  <= '0;
         snap_global <= '0;
         snap_x      <= 2'b0;
         snap_y      <= 2'b0;
         snap_seq    <= 16'h0;
         seq         <= 16'h0;
      end else if (accept) begin
         snap_local  <= local_cnt_i;
         snap_global <= global_cnt_i;
         snap_x      <= node_id_x_i;
         snap_y      <= node_id_y_i;
         snap_seq    <= seq;
         seq         <= seq + 16'h1;
      end
   end

   // Word index: cleared on capture, advanced on each handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word_idx <= '0;
      end else if (accept) begin
         word_idx <= '0;
      end else if (take && !at_last) begin
         word_idx <= word_idx + IDX_W'(1);
      end
   end

   // Done pulse for one cycle after the last word handshakes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         snap_done_o <= 1'b0;
      end else begin
         snap_done_o <= take && at_last;
      end
   end

endmodule

// File: tb/tb_perf_counter_readout.sv
// Scoreboard bench for perf_counter_readout: each accepted request pushes the
// expected frame (built from the inputs present at the request edge) into a
// queue; words on the output are compared against the queue head every valid
// cycle, which also checks that stalled words hold steady.
module tb_perf_counter_readout;
   localparam int N     = 5;
   localparam int LASTW = 4 * N;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [N*64-1:0]   local_cnt;
   logic [N*64-1:0]   global_cnt;
   logic [1:0]        nx, ny;
   logic              snap_req, rd_rdy;
   logic              snap_busy, snap_done, rd_vld, rd_last;
   logic [31:0]       rd_data;

   int          n_vec = 0;
   int          n_err = 0;
   logic [32:0] sb_q[$];
   logic [15:0] seq_model = 16'h0;
   bit          model_busy = 1'b0;
   bit          exp_done = 1'b0;
   int          hs_cnt = 0;
   int          done_cnt = 0;
   bit          cap = 1'b0;
   int          cap_n = 0;
   logic [31:0] cap_buf [0:LASTW];

   always #5 clk = ~clk;

   perf_counter_readout #(.INPUT_PORT_NUM(N), .CNT_W(64)) dut (
      .clk(clk), .rstn(rstn),
      .local_cnt_i(local_cnt), .global_cnt_i(global_cnt),
      .node_id_x_i(nx), .node_id_y_i(ny),
      .snap_req_i(snap_req), .snap_busy_o(snap_busy), .snap_done_o(snap_done),
      .rd_vld_o(rd_vld), .rd_rdy_i(rd_rdy), .rd_data_o(rd_data), .rd_last_o(rd_last)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_frame();
      sb_q.push_back({1'b0, 8'hA5, nx, ny, 4'(N), seq_model});
      for (int i = 0; i < N; i++) begin
         sb_q.push_back({1'b0, local_cnt[i*64 +: 32]});
         sb_q.push_back({1'b0, local_cnt[i*64+32 +: 32]});
         sb_q.push_back({1'b0, global_cnt[i*64 +: 32]});
         sb_q.push_back({(i == N-1), global_cnt[i*64+32 +: 32]});
      end
      seq_model = seq_model + 16'h1;
   endtask

   task automatic scramble_cnt();
      for (int i = 0; i < N; i++) begin
         local_cnt[i*64 +: 64]  = {$urandom, $urandom};
         global_cnt[i*64 +: 64] = {$urandom, $urandom};
      end
   endtask

   // One cycle: drive at the falling edge, check outputs just after it.
   task automatic step(input bit req, input bit rdy, input bit scr);
      logic [32:0] e;
      bit accept, last_hs;
      @(negedge clk);
      snap_req = req;
      rd_rdy   = rdy;
      if (scr) scramble_cnt();
      #1;
      check("busy", 64'(snap_busy), 64'(model_busy));
      check("vld", 64'(rd_vld), 64'(model_busy));
      check("done", 64'(snap_done), 64'(exp_done));
      if (snap_done) done_cnt++;
      accept  = req && !model_busy;
      last_hs = 1'b0;
      if (rd_vld) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(sb_q.size()), 64'd1);
         end else begin
            e = sb_q[0];
            check("data", 64'(rd_data), 64'(e[31:0]));
            check("last", 64'(rd_last), 64'(e[32]));
            if (rdy) begin
               void'(sb_q.pop_front());
               if (cap && cap_n <= LASTW) begin
                  cap_buf[cap_n] = rd_data;
                  cap_n++;
               end
               hs_cnt++;
               if (rd_last) begin
                  check("frame_len", 64'(hs_cnt), 64'(LASTW + 1));
                  hs_cnt = 0;
               end
               if (e[32]) last_hs = 1'b1;
            end
         end
      end
      exp_done = last_hs;
      if (accept) push_frame();
      model_busy = accept ? 1'b1 : (last_hs ? 1'b0 : model_busy);
   endtask

   // Run until the frame in flight has finished and its done pulse checked.
   task automatic drain(input bit rand_rdy, input bit scr);
      bit ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!model_busy && !exp_done && sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         step(1'b0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, scr);
      end
      if (!ok) check("drain_timeout", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int d0;
      snap_req   = 1'b0;
      rd_rdy     = 1'b0;
      local_cnt  = '0;
      global_cnt = '0;
      nx = 2'd0;
      ny = 2'd0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_vld", 64'(rd_vld), 64'd0);
      check("rst_last", 64'(rd_last), 64'd0);
      check("rst_data", 64'(rd_data), 64'd0);
      check("rst_busy", 64'(snap_busy), 64'd0);
      check("rst_done", 64'(snap_done), 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Directed frame with known counter values.
      local_cnt[0 +: 64]    = 64'h0000_0001_0000_0002;
      global_cnt[4*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
      nx = 2'd2;
      ny = 2'd1;
      cap = 1'b1;
      cap_n = 0;
      d0 = done_cnt;
      step(1'b1, 1'b1, 1'b0);
      drain(1'b0, 1'b0);
      cap = 1'b0;
      check("t1_hdr", 64'(cap_buf[0]), 64'hA595_0000);
      check("t1_w1", 64'(cap_buf[1]), 64'h0000_0002);
      check("t1_w2", 64'(cap_buf[2]), 64'h0000_0001);
      check("t1_w19", 64'(cap_buf[19]), 64'hFFFF_FFFF);
      check("t1_w20", 64'(cap_buf[20]), 64'hFFFF_FFFF);
      check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Counters change every cycle during the frame.
      step(1'b1, 1'b1, 1'b1);
      drain(1'b0, 1'b1);

      // Random backpressure.
      d0 = done_cnt;
      step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      drain(1'b1, 1'b1);
      check("bp_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Request held high: back-to-back frames, seq increments once per frame.
      d0 = done_cnt;
      repeat (70) step(1'b1, 1'b1, 1'b1);
      drain(1'b0, 1'b1);
      check("b2b_done_cnt", 64'(done_cnt - d0), 64'd4);

      // Sequence wrap 0xFFFF -> 0x0000.
      @(negedge clk);
      force dut.seq = 16'hFFFF;
      seq_model = 16'hFFFF;
      step(1'b0, 1'b1, 1'b0);
      release dut.seq;
      cap = 1'b1;
      cap_n = 0;
      step(1'b1, 1'b1, 1'b1);
      drain(1'b0, 1'b1);
      check("wrap_hdr_ffff", 64'(cap_buf[0][15:0]), 64'hFFFF);
      cap_n = 0;
      step(1'b1, 1'b1, 1'b1);
      drain(1'b0, 1'b1);
      check("wrap_hdr_0000", 64'(cap_buf[0][15:0]), 64'h0000);
      cap = 1'b0;

      // Reset while word 7 is on the bus.
      step(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 40 && hs_cnt < 7; k++) step(1'b0, 1'b1, 1'b1);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("mid_rst_vld", 64'(rd_vld), 64'd0);
      check("mid_rst_busy", 64'(snap_busy), 64'd0);
      check("mid_rst_done", 64'(snap_done), 64'd0);
      check("mid_rst_data", 64'(rd_data), 64'd0);
      sb_q.delete();
      model_busy = 1'b0;
      exp_done = 1'b0;
      seq_model = 16'h0;
      hs_cnt = 0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) step(1'b0, 1'b1, 1'b1);
      cap = 1'b1;
      cap_n = 0;
      step(1'b1, 1'b1, 1'b1);
      drain(1'b1, 1'b1);
      check("post_rst_seq", 64'(cap_buf[0][15:0]), 64'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
